// File: rtl/tcdm_bank_responder.sv
// ---------------------------------------------------------------------------
// tcdm_bank_responder
//
// Target-side endpoint of the request/response crossbar for one memory bank.
// Requests are issued straight to a fixed-latency SRAM macro. The tag of each
// request ({ini_addr, wen}) travels alongside the SRAM access in a valid-tagged
// shift pipeline. When the tag leaves the pipeline it is joined with the SRAM
// read data and queued in an in-order response FIFO. Every request gets exactly
// one response.
//
// Admission is credit based. A credit counter tracks requests that have been
// accepted but not yet popped from the response side. A request is accepted
// only while the counter is below RespFifoDepth. This guarantees a free FIFO
// slot for every SRAM read in flight, so the pipeline never has to stall and
// response backpressure never loses data.
//
// Optional build macro:
//   TCDM_BANK_RESPONDER_FALLTHROUGH_EN
//     If the FIFO is empty when an entry leaves the pipeline, that entry is
//     shown on resp_* in the same cycle. If it is consumed in that cycle, it
//     is never written to the FIFO. This lowers the response latency by one
//     cycle. When the macro is undefined, responses always come out of the
//     registered FIFO.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     request handshake
//   req_ini_addr_i          initiator tag, returned with the response
//   req_addr_i/wen_i/be_i/wdata_i  word address, 1=write, byte enables, data
//   resp_valid_o/ready_i    response handshake
//   resp_ini_addr_o         tag of the responded request
//   resp_rdata_o            read data (0 for writes)
//   mem_req_o/we_o/addr_o/be_o/wdata_o  SRAM command, asserted in accept cycle
//   mem_rdata_i             SRAM read data, MemLatency cycles after mem_req_o
// ---------------------------------------------------------------------------
module tcdm_bank_responder #(
    parameter int unsigned  NumIn         = 4,
    parameter int unsigned  AddrWidth     = 10,
    parameter int unsigned  DataWidth     = 32,
    parameter int unsigned  MemLatency    = 1,
    parameter int unsigned  RespFifoDepth = 2,
    localparam int unsigned IniAddrWidth  = (NumIn == 1) ? 1 : $clog2(NumIn),
    localparam int unsigned BeWidth       = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // crossbar request
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IniAddrWidth-1:0] req_ini_addr_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic                    req_wen_i,
    input  logic [BeWidth-1:0]      req_be_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    // crossbar response
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IniAddrWidth-1:0] resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    // SRAM macro
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrWidth-1:0]    mem_addr_o,
    output logic [BeWidth-1:0]      mem_be_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    // -----------------------------------------------------------------------
    // Elaboration checks
    // -----------------------------------------------------------------------
    if (MemLatency < 1 || MemLatency > 4) begin : g_bad_latency
        $fatal(1, "tcdm_bank_responder: MemLatency must be in 1..4");
    end
    if (RespFifoDepth < 1) begin : g_bad_depth
        $fatal(1, "tcdm_bank_responder: RespFifoDepth must be >= 1");
    end

    localparam int unsigned DepthC = (RespFifoDepth < 1) ? 1 : RespFifoDepth;
    localparam int unsigned CntW   = $clog2(DepthC + 1);
    localparam int unsigned PtrW   = (DepthC == 1) ? 1 : $clog2(DepthC);

    typedef struct packed {
        logic [IniAddrWidth-1:0] ini;
        logic                    wen;
    } tag_t;

    typedef struct packed {
        logic [IniAddrWidth-1:0] ini;
        logic [DataWidth-1:0]    data;
    } resp_t;

    // -----------------------------------------------------------------------
    // Handshakes and credit counter
    // -----------------------------------------------------------------------
    logic            accept;
    logic            pop;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign req_ready_o = !rst_i && (cnt_q < CntW'(DepthC));
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = resp_valid_o && resp_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // SRAM command: pass-through, qualified by accept
    // -----------------------------------------------------------------------
    assign mem_req_o   = accept;
    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_be_o    = req_be_i;
    assign mem_wdata_o = req_wdata_i;

    // -----------------------------------------------------------------------
    // Tag pipeline. It is kept aligned with the SRAM read latency. The last
    // stage is valid in the same cycle that mem_rdata_i carries its data.
    // -----------------------------------------------------------------------
    logic [MemLatency-1:0] vld_pipe_q, vld_pipe_d;
    tag_t [MemLatency-1:0] tag_pipe_q, tag_pipe_d;

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        tag_pipe_d    = tag_pipe_q;
        vld_pipe_d[0] = accept;
        tag_pipe_d[0] = '{ini: req_ini_addr_i, wen: req_wen_i};
        for (int k = 1; k < MemLatency; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            tag_pipe_d[k] = tag_pipe_q[k-1];
        end
    end

    logic  exit_vld;
    tag_t  exit_tag;
    resp_t exit_entry;

    assign exit_vld   = vld_pipe_q[MemLatency-1];
    assign exit_tag   = tag_pipe_q[MemLatency-1];
    // Write responses carry no data. Force zero so SRAM output noise never leaks.
    assign exit_entry = '{ini: exit_tag.ini, data: exit_tag.wen ? '0 : mem_rdata_i};

    // -----------------------------------------------------------------------
    // Response FIFO (circular buffer)
    // -----------------------------------------------------------------------
    resp_t [DepthC-1:0] fifo_q, fifo_d;
    logic  [PtrW-1:0]   wptr_q, wptr_d;
    logic  [PtrW-1:0]   rptr_q, rptr_d;
    logic  [CntW-1:0]   fcnt_q, fcnt_d;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    resp_t              head;

    assign fifo_empty = (fcnt_q == '0);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DepthC - 1)) ? '0 : p + PtrW'(1);
    endfunction

`ifdef TCDM_BANK_RESPONDER_FALLTHROUGH_EN
    logic bypass;
    // An exiting entry meets an empty FIFO. Present it directly and skip the
    // write when it is taken in the same cycle. Otherwise it lands in the
    // FIFO, and next cycle the FIFO head shows the same payload, so the
    // output stays stable.
    assign bypass       = fifo_empty && exit_vld;
    assign resp_valid_o = !rst_i && (!fifo_empty || exit_vld);
    assign head         = fifo_empty ? exit_entry : fifo_q[rptr_q];
    assign fifo_pop     = pop && !fifo_empty;
    assign fifo_push    = exit_vld && !(bypass && resp_ready_i);
`else
    assign resp_valid_o = !rst_i && !fifo_empty;
    assign head         = fifo_q[rptr_q];
    assign fifo_pop     = pop;
    // The push is unconditional. Credit admission guarantees a free slot.
    assign fifo_push    = exit_vld;
`endif

    assign resp_ini_addr_o = head.ini;
    assign resp_rdata_o    = head.data;

    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        if (fifo_push) begin
            fifo_d[wptr_q] = exit_entry;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (fifo_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (fifo_push && !fifo_pop) begin
            fcnt_d = fcnt_q + CntW'(1);
        end else if (!fifo_push && fifo_pop) begin
            fcnt_d = fcnt_q - CntW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // Reset drops everything in flight. Without a valid bit, the payload
    // storage is never observed, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_pipe_q <= tag_pipe_d;
        fifo_q     <= fifo_d;
    end

    // -----------------------------------------------------------------------
    // Simulation-only sanity checks
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(accept && !pop && cnt_q == CntW'(DepthC)));
            assert (!(pop && !accept && cnt_q == '0));
            assert (!(fifo_push && !fifo_pop && fcnt_q == CntW'(DepthC)));
        end
    end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Two instances share one stimulus stream: (MemLatency=1, depth=2) and
// (MemLatency=2, depth=3). Each instance is scored against its own reference
// model. The model is a queue of outstanding requests. Each entry holds its
// expected tag and data, plus the cycle from which it may show at the head.
module tb_tcdm_bank_responder;
    localparam int IW = 2, AW = 10, DW = 32, BW = 4;
    localparam int LAT [2] = '{1, 2};
    localparam int DEP [2] = '{2, 3};
`ifdef TCDM_BANK_RESPONDER_FALLTHROUGH_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_wen, resp_ready;
    logic [IW-1:0] req_ini;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata;

    logic          rdy   [2];
    logic          rv    [2];
    logic [IW-1:0] rini  [2];
    logic [DW-1:0] rdat  [2];
    logic          mreq  [2];
    logic          mwe   [2];
    logic [AW-1:0] maddr [2];
    logic [BW-1:0] mbe   [2];
    logic [DW-1:0] mwd   [2];
    logic [DW-1:0] mrd   [2];

    always #5 clk = ~clk;

    tcdm_bank_responder #(.NumIn(4), .AddrWidth(AW), .DataWidth(DW), .MemLatency(1), .RespFifoDepth(2)) u0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(rdy[0]), .req_ini_addr_i(req_ini), .req_addr_i(req_addr),
        .req_wen_i(req_wen), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .resp_valid_o(rv[0]), .resp_ready_i(resp_ready), .resp_ini_addr_o(rini[0]), .resp_rdata_o(rdat[0]),
        .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_be_o(mbe[0]),
        .mem_wdata_o(mwd[0]), .mem_rdata_i(mrd[0]));

    tcdm_bank_responder #(.NumIn(4), .AddrWidth(AW), .DataWidth(DW), .MemLatency(2), .RespFifoDepth(3)) u1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(rdy[1]), .req_ini_addr_i(req_ini), .req_addr_i(req_addr),
        .req_wen_i(req_wen), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .resp_valid_o(rv[1]), .resp_ready_i(resp_ready), .resp_ini_addr_o(rini[1]), .resp_rdata_o(rdat[1]),
        .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_be_o(mbe[1]),
        .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1]));

    // SRAM macro models, driven only by the DUT mem_* outputs.
    logic [DW-1:0] sram [2][1024] = '{default: '0};
    logic [DW-1:0] rd_a [2] = '{default: '0};
    logic [DW-1:0] rd_b [2] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mreq[i] === 1'b1) begin
                if (mwe[i]) begin
                    for (int b = 0; b < BW; b++)
                        if (mbe[i][b]) sram[i][maddr[i]][b*8 +: 8] <= mwd[i][b*8 +: 8];
                end else begin
                    rd_a[i] <= sram[i][maddr[i]];
                end
            end
            rd_b[i] <= rd_a[i];
        end
    end
    assign mrd[0] = rd_a[0];
    assign mrd[1] = rd_b[1];

    // Reference model state
    typedef struct {
        logic [IW-1:0] ini;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          mq [2][$];
    logic [DW-1:0] ref_mem [2][1024];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    bit            acc  [2];
    bit            popx [2];
    int            dut_acc [2];
    logic [IW-1:0] lg_ini [$];
    logic [DW-1:0] lg_dat [$];

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h (cycle %0d)", tag, inst, obs, exp, cyc);
        end
    endtask

    // Compare DUT outputs with the model. Called mid-cycle, away from the
    // active edge.
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit er, ev;
            er = !rst && (mq[i].size() < DEP[i]);
            ev = 1'b0;
            if (!rst && mq[i].size() != 0) ev = (mq[i][0].due <= cyc);
            chk("req_ready", i, 64'(rdy[i]), 64'(er));
            chk("resp_valid", i, 64'(rv[i]), 64'(ev));
            if (ev) begin
                chk("resp_ini", i, 64'(rini[i]), 64'(mq[i][0].ini));
                chk("resp_rdata", i, 64'(rdat[i]), 64'(mq[i][0].data));
            end
            chk("mem_req", i, 64'(mreq[i]), 64'(req_valid && er));
            if (req_valid && er) begin
                chk("mem_we", i, 64'(mwe[i]), 64'(req_wen));
                chk("mem_addr", i, 64'(maddr[i]), 64'(req_addr));
                chk("mem_be", i, 64'(mbe[i]), 64'(req_be));
                chk("mem_wdata", i, 64'(mwd[i]), 64'(req_wdata));
            end
            if (mreq[i] === 1'b1) dut_acc[i]++;
            acc[i]  = req_valid && er;
            popx[i] = ev && resp_ready;
            if (i == 0 && ev && resp_ready) begin
                lg_ini.push_back(rini[0]);
                lg_dat.push_back(rdat[0]);
            end
        end
    endtask

    // Advance the model at the clock edge, using the inputs of the ending cycle.
    task automatic update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
            end else begin
                if (popx[i]) void'(mq[i].pop_front());
                if (acc[i]) begin
                    exp_t e;
                    e.ini = req_ini;
                    e.due = cyc + LAT[i] + EXTRA;
                    if (req_wen) begin
                        for (int b = 0; b < BW; b++)
                            if (req_be[b]) ref_mem[i][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                        e.data = '0;
                    end else begin
                        e.data = ref_mem[i][req_addr];
                    end
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        update();
        cyc++;
        #1;
    endtask

    task automatic drv(input bit v, input int ini, input int addr, input bit wen, input int be, input logic [31:0] wd);
        req_valid = v;
        req_ini   = IW'(ini);
        req_addr  = AW'(addr);
        req_wen   = wen;
        req_be    = BW'(be);
        req_wdata = wd;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 1024; a++) ref_mem[i][a] = '0;
        dut_acc[0] = 0;
        dut_acc[1] = 0;
        rst = 1'b1;
        resp_ready = 1'b1;
        drv(0, 0, 0, 0, 0, 32'h0);

        // Reset: ready and valid must stay low.
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b0;

        // Preload through the bank itself.
        drv(1, 0, 'h010, 1, 'hF, 32'hDEADBEEF); tick();
        drv(1, 0, 'h003, 1, 'hF, 32'hFFFFFFFF); tick();
        idle(4);

        // Single read, tag 2
        lg_ini.delete(); lg_dat.delete();
        drv(1, 2, 'h010, 0, 'hF, 32'h0); tick();
        idle(4);
        chk("t1_count", 0, 64'(lg_ini.size()), 64'd1);
        if (lg_ini.size() >= 1) begin
            chk("t1_ini", 0, 64'(lg_ini[0]), 64'd2);
            chk("t1_rdata", 0, 64'(lg_dat[0]), 64'hDEADBEEF);
        end

        // Partial write then read of the same word
        lg_ini.delete(); lg_dat.delete();
        drv(1, 1, 'h003, 1, 'h3, 32'hA5A5A5A5); tick();
        drv(1, 0, 'h003, 0, 'hF, 32'h0); tick();
        idle(5);
        chk("t2_count", 0, 64'(lg_ini.size()), 64'd2);
        if (lg_ini.size() >= 2) begin
            chk("t2_ini0", 0, 64'(lg_ini[0]), 64'd1);
            chk("t2_rdata0", 0, 64'(lg_dat[0]), 64'd0);
            chk("t2_ini1", 0, 64'(lg_ini[1]), 64'd0);
            chk("t2_rdata1", 0, 64'(lg_dat[1]), 64'hFFFFA5A5);
        end

        // Backpressure: admission stops at the FIFO depth.
        lg_ini.delete(); lg_dat.delete();
        dut_acc[0] = 0; dut_acc[1] = 0;
        resp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drv(1, k % 4, k, 0, 'hF, 32'h0);
            tick();
        end
        chk("bp_accepts", 0, 64'(dut_acc[0]), 64'd2);
        chk("bp_accepts", 1, 64'(dut_acc[1]), 64'd3);
        drv(0, 0, 0, 0, 0, 32'h0);
        resp_ready = 1'b1;
        idle(6);
        chk("bp_count", 0, 64'(lg_ini.size()), 64'd2);
        if (lg_ini.size() >= 2) begin
            chk("bp_order0", 0, 64'(lg_ini[0]), 64'd0);
            chk("bp_order1", 0, 64'(lg_ini[1]), 64'd1);
        end

        // Streaming: 16 reads. Each one is held until u1 takes it.
        dut_acc[1] = 0;
        for (int k = 0; k < 16; k++) begin
            int g;
            g = 0;
            drv(1, k % 4, 'h020 + k, 0, 'hF, 32'h0);
            do begin
                tick();
                g++;
            end while (!acc[1] && g < 8);
            chk("stream_accept", 1, 64'(acc[1]), 64'd1);
        end
        idle(8);
        chk("stream_total", 1, 64'(dut_acc[1]), 64'd16);

        // Accept and pop in the same cycle, one below the depth
        drv(1, 1, 'h010, 0, 'hF, 32'h0); tick();
        idle(1);
        drv(1, 2, 'h003, 0, 'hF, 32'h0); tick();
        drv(1, 3, 'h010, 0, 'hF, 32'h0); tick();
        idle(6);

        // Reset while responses are queued and in flight
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(1, k, 'h010, 0, 'hF, 32'h0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        resp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        lg_ini.delete(); lg_dat.delete();
        idle(4);
        chk("rst_no_stale", 0, 64'(lg_ini.size()), 64'd0);
        drv(1, 3, 'h010, 0, 'hF, 32'h0); tick();
        idle(5);
        chk("rst_new_count", 0, 64'(lg_ini.size()), 64'd1);
        if (lg_ini.size() >= 1) begin
            chk("rst_new_ini", 0, 64'(lg_ini[0]), 64'd3);
            chk("rst_new_rdata", 0, 64'(lg_dat[0]), 64'hDEADBEEF);
        end

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drv(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)), 32'($urandom));
            resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        resp_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
